// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall merge, redirect sequencing and perf counters
module pipe_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stallreq_if,
  input  logic             i_stallreq_id,
  input  logic             i_stallreq_ex,
  input  logic             i_stallreq_mem,
  input  logic             i_ex_redirect,
  input  logic [XLEN-1:0]  i_ex_redirect_pc,
  input  logic             i_mem_excp,
  input  logic [XLEN-1:0]  i_excp_vec,
  output logic [5:0]       o_stall,
  output logic             o_flush,
  output logic             o_flush_ex,
  output logic [XLEN-1:0]  o_new_pc,
  output logic             o_pending,
  output logic [CNT_W-1:0] o_perf_stall_cnt,
  output logic [CNT_W-1:0] o_perf_flush_cnt
);

  typedef enum logic [1:0] {IDLE, PEND_BR, PEND_EXC} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [XLEN-1:0]  r_pend_pc;
  logic [XLEN-1:0]  w_pend_pc_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [5:0]       w_raw_stall;
  logic             w_ex_ok;
  logic             w_exc_ok;
  logic             w_flush;
  logic             w_flush_ex;
  logic [XLEN-1:0]  w_new_pc;

  always_comb begin
    w_raw_stall = 6'b000000;
    if (i_stallreq_mem)     w_raw_stall = 6'b011111;
    else if (i_stallreq_ex) w_raw_stall = 6'b001111;
    else if (i_stallreq_id) w_raw_stall = 6'b000111;
    else if (i_stallreq_if) w_raw_stall = 6'b000011;
  end

  assign w_ex_ok  = !i_stallreq_ex && !i_stallreq_mem;
  assign w_exc_ok = !i_stallreq_mem;

  // An exception always beats a branch: it belongs to the older instruction.
  always_comb begin
    w_state_nxt   = r_state;
    w_pend_pc_nxt = r_pend_pc;
    w_flush       = 1'b0;
    w_flush_ex    = 1'b0;
    w_new_pc      = '0;
    case (r_state)
      IDLE, PEND_BR: begin
        if (i_mem_excp) begin
          if (w_exc_ok) begin
            w_flush     = 1'b1;
            w_flush_ex  = 1'b1;
            w_new_pc    = i_excp_vec;
            w_state_nxt = IDLE;
          end else begin
            w_pend_pc_nxt = i_excp_vec;
            w_state_nxt   = PEND_EXC;
          end
        end else if (r_state == PEND_BR) begin
          if (w_ex_ok) begin
            w_flush     = 1'b1;
            w_new_pc    = r_pend_pc;
            w_state_nxt = IDLE;
          end
        end else if (i_ex_redirect) begin
          if (w_ex_ok) begin
            w_flush  = 1'b1;
            w_new_pc = i_ex_redirect_pc;
          end else begin
            w_pend_pc_nxt = i_ex_redirect_pc;
            w_state_nxt   = PEND_BR;
          end
        end
      end
      PEND_EXC: begin
        if (w_exc_ok) begin
          w_flush     = 1'b1;
          w_flush_ex  = 1'b1;
          w_new_pc    = r_pend_pc;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (i_rst) begin
      w_flush    = 1'b0;
      w_flush_ex = 1'b0;
      w_new_pc   = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_pend_pc   <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pend_pc <= w_pend_pc_nxt;
      if ((o_stall != 6'b000000) && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush && (r_flush_cnt != {CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign o_stall          = (i_rst || w_flush) ? 6'b000000 : w_raw_stall;
  assign o_flush          = w_flush;
  assign o_flush_ex       = w_flush_ex;
  assign o_new_pc         = w_new_pc;
  assign o_pending        = !i_rst && (r_state != IDLE);
  assign o_perf_stall_cnt = i_rst ? '0 : r_stall_cnt;
  assign o_perf_flush_cnt = i_rst ? '0 : r_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             sr_if, sr_id, sr_ex, sr_mem;
  logic             ex_redirect, mem_excp;
  logic [XLEN-1:0]  ex_redirect_pc, excp_vec;
  logic [5:0]       stall;
  logic             flush, flush_ex, pending;
  logic [XLEN-1:0]  new_pc;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_stallreq_if    (sr_if),
    .i_stallreq_id    (sr_id),
    .i_stallreq_ex    (sr_ex),
    .i_stallreq_mem   (sr_mem),
    .i_ex_redirect    (ex_redirect),
    .i_ex_redirect_pc (ex_redirect_pc),
    .i_mem_excp       (mem_excp),
    .i_excp_vec       (excp_vec),
    .o_stall          (stall),
    .o_flush          (flush),
    .o_flush_ex       (flush_ex),
    .o_new_pc         (new_pc),
    .o_pending        (pending),
    .o_perf_stall_cnt (stall_cnt),
    .o_perf_flush_cnt (flush_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_in();
    sr_if = 0; sr_id = 0; sr_ex = 0; sr_mem = 0;
    ex_redirect = 0; mem_excp = 0;
    ex_redirect_pc = '0; excp_vec = '0;
  endtask

  initial begin
    clear_in();
    rst = 1;
    tick();
    // Inputs ignored and outputs quiet while in reset
    sr_mem = 1; mem_excp = 1; excp_vec = 32'h8;
    settle();
    check("rst_stall", stall, 6'h00);
    check("rst_flush", flush, 0);
    check("rst_new_pc", new_pc, 0);
    tick();
    rst = 0; clear_in();
    settle();
    check("init_pending", pending, 0);
    check("init_stall_cnt", stall_cnt, 0);
    check("init_flush_cnt", flush_cnt, 0);

    // Priority encoding
    sr_if = 1; sr_ex = 1; settle(); check("prio_if_ex", stall, 6'b001111); tick();
    sr_mem = 1; settle(); check("prio_mem", stall, 6'b011111); tick();
    clear_in(); sr_id = 1; settle(); check("prio_id", stall, 6'b000111); tick();
    clear_in(); sr_if = 1; settle(); check("prio_if", stall, 6'b000011); tick();
    clear_in(); settle();
    check("prio_none", stall, 6'b000000);
    check("prio_stall_cnt", stall_cnt, 4);

    // Immediate branch overrides a concurrent ID stall
    sr_id = 1; ex_redirect = 1; ex_redirect_pc = 32'h8000_0040; settle();
    check("imm_flush", flush, 1);
    check("imm_flush_ex", flush_ex, 0);
    check("imm_new_pc", new_pc, 32'h8000_0040);
    check("imm_stall", stall, 6'b000000);
    check("imm_pending_now", pending, 0);
    tick(); clear_in(); settle();
    check("imm_pending_after", pending, 0);
    check("imm_flush_cnt", flush_cnt, 1);
    check("imm_stall_cnt", stall_cnt, 4);

    // Pending branch held by EX busy
    sr_ex = 1; ex_redirect = 1; ex_redirect_pc = 32'h100; settle();
    check("pbr_flush_pulse", flush, 0);
    tick(); ex_redirect = 0; ex_redirect_pc = '0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("pbr_pending_hold", pending, 1);
      check("pbr_flush_hold", flush, 0);
      tick();
    end
    sr_ex = 0; settle();
    check("pbr_flush", flush, 1);
    check("pbr_new_pc", new_pc, 32'h100);
    check("pbr_flush_ex", flush_ex, 0);
    check("pbr_pending_in_flush", pending, 1);
    tick(); settle();
    check("pbr_pending_clear", pending, 0);
    check("pbr_no_second_flush", flush, 0);
    check("pbr_stall_cnt", stall_cnt, 8);
    check("pbr_flush_cnt", flush_cnt, 2);

    // Exception pre-empts a pending branch
    sr_mem = 1; ex_redirect = 1; ex_redirect_pc = 32'h200; tick();
    ex_redirect = 0; ex_redirect_pc = '0; settle();
    check("pre_pending_br", pending, 1);
    mem_excp = 1; excp_vec = 32'h8; settle();
    check("pre_flush_blocked", flush, 0);
    tick(); mem_excp = 0; excp_vec = '0; settle();
    check("pre_pending_exc", pending, 1);
    check("pre_flush_wait", flush, 0);
    tick();
    sr_mem = 0; settle();
    check("pre_flush", flush, 1);
    check("pre_flush_ex", flush_ex, 1);
    check("pre_new_pc", new_pc, 32'h8);
    tick(); settle();
    check("pre_no_branch_flush", flush, 0);
    check("pre_pending_clear", pending, 0);
    check("pre_flush_cnt", flush_cnt, 3);
    check("pre_stall_cnt", stall_cnt, 11);

    // Simultaneous exception and branch with no stall
    mem_excp = 1; excp_vec = 32'h8; ex_redirect = 1; ex_redirect_pc = 32'h300; settle();
    check("sim_flush", flush, 1);
    check("sim_flush_ex", flush_ex, 1);
    check("sim_new_pc", new_pc, 32'h8);
    tick(); clear_in(); settle();
    check("sim_flush_after", flush, 0);
    check("sim_pending", pending, 0);
    check("sim_flush_cnt", flush_cnt, 4);

    // Stall counter saturates at all-ones
    sr_if = 1;
    for (int i = 0; i < 10; i++) tick();
    clear_in(); settle();
    check("sat_stall_cnt", stall_cnt, 4'hF);
    tick(); sr_if = 1; tick(); clear_in(); settle();
    check("sat_stall_hold", stall_cnt, 4'hF);

    // Reset while a branch is pending discards it
    sr_ex = 1; ex_redirect = 1; ex_redirect_pc = 32'h100; tick();
    clear_in(); settle();
    check("rstp_pending_set", pending, 1);
    rst = 1; settle();
    check("rstp_flush_in_rst", flush, 0);
    check("rstp_pending_in_rst", pending, 0);
    tick(); rst = 0; settle();
    check("rstp_pending", pending, 0);
    check("rstp_stall_cnt", stall_cnt, 0);
    check("rstp_flush_cnt", flush_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      check("rstp_no_flush", flush, 0);
      tick(); settle();
    end
    check("rstp_flush_cnt_end", flush_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
